// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with a shift-add multiplier.
// The 5-bit opcode map is the same as the older combinational ALU's.
// Optional build macro ALU_FLAGS_EN adds the registered zf/cf/vf flag outputs.
module alu_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             err
`ifdef ALU_FLAGS_EN
  ,
  output logic             zf,
  output logic             cf,
  output logic             vf
`endif
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_MUL = 5'b00010;
  localparam logic [4:0] OP_SHR = 5'b00100;
  localparam logic [4:0] OP_SHL = 5'b00101;
  localparam logic [4:0] OP_AND = 5'b01000;
  localparam logic [4:0] OP_OR  = 5'b01001;
  localparam logic [4:0] OP_XOR = 5'b01010;
  localparam logic [4:0] OP_GE  = 5'b01100;
  localparam logic [4:0] OP_EQ  = 5'b01101;
  localparam logic [4:0] OP_NOT = 5'b10010;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic             accept, mul_step, mul_last;
  logic [WIDTH-1:0] acc, mcand, mplier, acc_add;
  logic [SHW-1:0]   cnt, sh;
  logic             sh_big;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;

  // Shift amount; any bit above the low SHW bits forces a zero result
  assign sh     = a[SHW-1:0];
  assign sh_big = |(a >> SHW);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and input handshake; a retiring DONE may accept in the same cycle
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mul_step  = 1'b0;
    mul_last  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      MUL: begin
        mul_step = 1'b1;
        if (cnt == SHW'(WIDTH - 1)) begin
          mul_last  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    accept = in_valid && in_ready;
    if (accept) state_nxt = (f == OP_MUL) ? MUL : DONE;
  end

  // Single-cycle operations evaluated on the presented operands
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (f)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_MUL:  alu_res = '0;
      OP_SHR:  alu_res = sh_big ? '0 : (b >> sh);
      OP_SHL:  alu_res = sh_big ? '0 : (b << sh);
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_GE:   alu_res = WIDTH'(a >= b);
      OP_EQ:   alu_res = WIDTH'(a == b);
      OP_NOT:  alu_res = ~b;
      default: alu_err = 1'b1;
    endcase
  end

  assign acc_add = acc + (mplier[0] ? mcand : '0);

  // Shift-add multiplier: one multiplier bit per cycle, WIDTH cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (accept && (f == OP_MUL)) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      cnt    <= '0;
    end else if (mul_step) begin
      acc    <= acc_add;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + SHW'(1);
    end
  end

  // Result registers; held until a new result is loaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s         <= '0;
      err       <= 1'b0;
    end else begin
      out_valid <= (state_nxt == DONE);
      if (accept && (f != OP_MUL)) begin
        s   <= alu_res;
        err <= alu_err;
      end else if (mul_last) begin
        s   <= acc_add;
        err <= 1'b0;
      end
    end
  end

`ifdef ALU_FLAGS_EN
  logic           flag_cf, flag_vf;
  logic [SHW-1:0] sh_neg, sh_m1;

  // Bit index of the last bit shifted out: WIDTH-sh for SHL, sh-1 for SHR
  assign sh_neg = SHW'(0) - sh;
  assign sh_m1  = sh - SHW'(1);

  // Carry and signed-overflow for the operation being accepted
  always_comb begin
    flag_cf = 1'b0;
    flag_vf = 1'b0;
    case (f)
      OP_ADD: begin
        flag_cf = (alu_res < a);
        flag_vf = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        flag_cf = (a >= b);
        flag_vf = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHL:  flag_cf = !sh_big && (sh != '0) && b[sh_neg];
      OP_SHR:  flag_cf = !sh_big && (sh != '0) && b[sh_m1];
      default: ;
    endcase
  end

  // Flag registers, loaded together with s
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf <= 1'b0;
      cf <= 1'b0;
      vf <= 1'b0;
    end else if (accept && (f != OP_MUL)) begin
      zf <= (alu_res == '0);
      cf <= flag_cf;
      vf <= flag_vf;
    end else if (mul_last) begin
      zf <= (acc_add == '0);
      cf <= 1'b0;
      vf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): directed table, corner sequences, random vs model.
module tb_alu_seq;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready, err;
  logic [W-1:0] a, b, s;
  logic [4:0]   f;
`ifdef ALU_FLAGS_EN
  logic         zf, cf, vf;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .f(f), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .err(err)
`ifdef ALU_FLAGS_EN
    , .zf(zf), .cf(cf), .vf(vf)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  f;
    logic [15:0] exp_s;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t       vt[15];
  logic [4:0] nm_ops[10];
  logic [4:0] all_ops[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference computed from the opcode definitions with plain arithmetic
  function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic [4:0] mf,
                                output logic [15:0] ms, output logic me);
    int unsigned x, y;
    x  = ma;
    y  = mb;
    me = 1'b0;
    ms = 16'h0000;
    case (mf)
      5'd0:  ms = 16'((x + y) % 65536);
      5'd1:  ms = 16'((x + 65536 - y) % 65536);
      5'd2:  ms = 16'((x * y) % 65536);
      5'd4:  ms = (x >= 16) ? 16'h0000 : 16'(y / (2 ** x));
      5'd5:  ms = (x >= 16) ? 16'h0000 : 16'((y * (2 ** x)) % 65536);
      5'd8:  ms = ma & mb;
      5'd9:  ms = ma | mb;
      5'd10: ms = ma ^ mb;
      5'd12: ms = (x >= y) ? 16'h0001 : 16'h0000;
      5'd13: ms = (x == y) ? 16'h0001 : 16'h0000;
      5'd18: ms = ~mb;
      default: me = 1'b1;
    endcase
  endfunction

  // Issue one op when idle, wait (bounded) for its result; lat counts cycles after accept
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic [4:0] tf,
                        output logic [15:0] rs, output logic re, output int lat);
    @(negedge clk);
    a = ta; b = tb_v; f = tf; in_valid = 1'b1;
    #1 chk("in_ready_at_issue", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); f = 5'($urandom);
    lat = 99;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    rs = s;
    re = err;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rs, es, exp_q[4];
    logic        re, ee;
    int          lat, k, bad;

    vt[0]  = '{16'h0000, 16'h1234, 5'b00000, 16'h1234, 1'b0, 1};
    vt[1]  = '{16'h000A, 16'h0100, 5'b00010, 16'h0A00, 1'b0, 17};
    vt[2]  = '{16'hFFFF, 16'hFFFF, 5'b00010, 16'h0001, 1'b0, 17};
    vt[3]  = '{16'h0008, 16'h1234, 5'b00100, 16'h0012, 1'b0, 1};
    vt[4]  = '{16'h0010, 16'h1234, 5'b00100, 16'h0000, 1'b0, 1};
    vt[5]  = '{16'h0000, 16'h1234, 5'b10010, 16'hEDCB, 1'b0, 1};
    vt[6]  = '{16'h1010, 16'hFFFF, 5'b01000, 16'h1010, 1'b0, 1};
    vt[7]  = '{16'h0005, 16'h0004, 5'b01100, 16'h0001, 1'b0, 1};
    vt[8]  = '{16'h0004, 16'h0005, 5'b01100, 16'h0000, 1'b0, 1};
    vt[9]  = '{16'h1234, 16'h5678, 5'b11111, 16'h0000, 1'b1, 1};
    vt[10] = '{16'h0005, 16'h0007, 5'b00001, 16'hFFFE, 1'b0, 1};
    vt[11] = '{16'h0004, 16'h1234, 5'b00101, 16'h2340, 1'b0, 1};
    vt[12] = '{16'h0100, 16'h1234, 5'b00101, 16'h0000, 1'b0, 1};
    vt[13] = '{16'h0007, 16'h0007, 5'b01101, 16'h0001, 1'b0, 1};
    vt[14] = '{16'h0F0F, 16'h00FF, 5'b01010, 16'h0FF0, 1'b0, 1};
    nm_ops  = '{5'd0, 5'd1, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12, 5'd13, 5'd18};
    all_ops = '{5'd0, 5'd1, 5'd2, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12, 5'd13, 5'd18};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; f = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 15; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].f, rs, re, lat);
      chk($sformatf("vec%0d_s", i), 32'(rs), 32'(vt[i].exp_s));
      chk($sformatf("vec%0d_err", i), 32'(re), 32'(vt[i].exp_err));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].exp_lat));
    end

    // MUL busy window: no ready, no valid for WIDTH cycles, then result
    @(negedge clk);
    a = 16'h0003; b = 16'h0005; f = 5'b00010; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    bad = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (in_ready || out_valid) bad++;
    end
    chk("mul_busy_cycles", 32'(bad), 32'd0);
    @(negedge clk);
    chk("mul_busy_result", 32'({out_valid, s}), 32'({1'b1, 16'h000F}));

    // Backpressure: hold SUB result 3 cycles, then 4 back-to-back ops
    @(negedge clk);
    out_ready = 1'b0;
    run_op(16'h0009, 16'h0004, 5'b00001, rs, re, lat);
    chk("bp_sub_s", 32'(rs), 32'h0005);
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold", 32'({out_valid, in_ready, s}), 32'({1'b1, 1'b0, 16'h0005}));
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 16'($urandom_range(0, 20));
      b = 16'($urandom);
      f = nm_ops[$urandom_range(0, 9)];
      model(a, b, f, exp_q[i], ee);
      in_valid = 1'b1;
      #1 chk("b2b_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      chk($sformatf("b2b%0d", i), 32'({out_valid, s}), 32'({1'b1, exp_q[i]}));
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_drain", 32'(out_valid), 32'd0);

    // Reset in the middle of a multiply
    run_op(16'h1111, 16'h2222, 5'b00000, rs, re, lat);
    chk("pre_rst_add", 32'(rs), 32'h3333);
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; f = 5'b00010; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("rst_mid_mul", 32'({out_valid, err, s}), 32'd0);
    chk("rst_mid_mul_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("no_stale_mul", 32'(bad), 32'd0);
    run_op(16'h0001, 16'h0002, 5'b00000, rs, re, lat);
    chk("post_rst_add", 32'({re, rs}), 32'({1'b0, 16'h0003}));

`ifdef ALU_FLAGS_EN
    run_op(16'h7FFF, 16'h0001, 5'b00000, rs, re, lat);
    chk("flags_add_ovf", 32'({rs, zf, cf, vf}), 32'({16'h8000, 3'b001}));
    run_op(16'h0005, 16'h0005, 5'b00001, rs, re, lat);
    chk("flags_sub_zero", 32'({rs, zf, cf, vf}), 32'({16'h0000, 3'b110}));
`endif

    // Randomized ops against the reference model, with random result stalls
    for (int i = 0; i < 60; i++) begin
      logic [15:0] ra, rb;
      logic [4:0]  rf;
      ra = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 17));
      rb = 16'($urandom);
      rf = ($urandom_range(0, 3) == 0) ? 5'($urandom) : all_ops[$urandom_range(0, 10)];
      model(ra, rb, rf, es, ee);
      run_op(ra, rb, rf, rs, re, lat);
      chk($sformatf("rnd%0d_f%0d_s", i, rf), 32'(rs), 32'(es));
      chk($sformatf("rnd%0d_err", i), 32'(re), 32'(ee));
      chk($sformatf("rnd%0d_lat", i), 32'(lat), (rf == 5'd2) ? 32'd17 : 32'd1);
      if ($urandom_range(0, 2) == 0) begin
        out_ready = 1'b0;
        k = $urandom_range(1, 3);
        repeat (k) begin
          @(negedge clk);
          chk("rnd_stall_hold", 32'({out_valid, in_ready, err, s}), 32'({1'b1, 1'b0, ee, es}));
        end
        out_ready = 1'b1;
      end
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
